// File: rtl/game_status_if.sv
// +----------------------------------------------------------------------------+
// | Module : game_status_if                                                    |
// | Brief  : Collision-detector inputs and game status outputs of the status   |
// |          controller.                                                       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface game_status_if;
   logic       startOfFrame;
   logic       player_hit;
   logic       enemy_killed;
   logic [2:0] lives;
   logic [7:0] kills;
   logic       invuln;
   logic       hit_pulse;
   logic       gameOver;
   logic       win;

   modport master (
      output startOfFrame, player_hit, enemy_killed,
      input  lives, kills, invuln, hit_pulse, gameOver, win
   );

   modport slave (
      input  startOfFrame, player_hit, enemy_killed,
      output lives, kills, invuln, hit_pulse, gameOver, win
   );
endinterface

`default_nettype wire

// File: rtl/game_status_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module : game_status_ctrl                                                  |
// | Brief  : Lives/kills bookkeeping with hit immunity and terminal gameOver / |
// |          win levels. Optional macro BONUS_LIFE_EN grants bonus lives.      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module game_status_ctrl #(
   parameter int LIVES_INIT    = 3,
   parameter int KILLS_TO_WIN  = 20,
   parameter int INVULN_FRAMES = 60,
   parameter int BONUS_KILLS   = 10,
   parameter int MAX_LIVES     = 7
) (
   input  wire logic     clk,
   input  wire logic     resetN,
   game_status_if.slave  bus
);

   typedef enum logic [1:0] {
      S_PLAY     = 2'd0,
      S_INVULN   = 2'd1,
      S_GAMEOVER = 2'd2,
      S_WIN      = 2'd3
   } state_t;

   localparam logic [2:0] c_LIVES_RST  = 3'(LIVES_INIT);
   localparam logic [7:0] c_KILL_LAST  = 8'(KILLS_TO_WIN - 1);
   localparam logic [7:0] c_INV_FRAMES = 8'(INVULN_FRAMES);

   // Empty marker scope: present in the hierarchy only for an illegal configuration.
   if (LIVES_INIT < 1 || LIVES_INIT > 7 || MAX_LIVES > 7 || BONUS_KILLS < 1) begin : g_cfg_invalid
   end

   state_t     state_q, state_d;
   logic [2:0] lives_q, lives_d;
   logic [7:0] kills_q, kills_d;
   logic [7:0] frames_q, frames_d;
   logic       hit_pulse_q, hit_pulse_d;

   logic       w_active;
   logic       w_kill;
   logic       w_win;
   logic       w_hit;
   logic       w_bonus;
   logic [2:0] w_lives_up;

   assign w_active = (state_q == S_PLAY) || (state_q == S_INVULN);
   assign w_kill   = bus.enemy_killed && w_active;
   assign w_win    = w_kill && (kills_q == c_KILL_LAST);
   assign w_hit    = bus.player_hit && (state_q == S_PLAY) && !w_win;

`ifdef BONUS_LIFE_EN
   localparam logic [7:0] c_BONUS_LAST = 8'(BONUS_KILLS - 1);
   localparam logic [2:0] c_LIVES_MAX  = 3'(MAX_LIVES);

   logic [7:0] bonus_cnt_q;

   // Counts kills modulo BONUS_KILLS so no divider is needed.
   assign w_bonus    = w_kill && (bonus_cnt_q == c_BONUS_LAST);
   assign w_lives_up = (lives_q < c_LIVES_MAX) ? lives_q + 3'd1 : lives_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         bonus_cnt_q <= '0;
      end else if (w_kill) begin
         bonus_cnt_q <= w_bonus ? 8'd0 : bonus_cnt_q + 8'd1;
      end
   end
`else
   assign w_bonus    = 1'b0;
   assign w_lives_up = lives_q;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_PLAY;
         lives_q     <= c_LIVES_RST;
         kills_q     <= '0;
         frames_q    <= '0;
         hit_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         kills_q     <= kills_d;
         frames_q    <= frames_d;
         hit_pulse_q <= hit_pulse_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      kills_d     = kills_q;
      frames_d    = frames_q;
      hit_pulse_d = 1'b0;

      if (w_kill) begin
         kills_d = kills_q + 8'd1;
      end

      case (state_q)
         S_PLAY, S_INVULN: begin
            if (w_win) begin
               state_d = S_WIN;
               lives_d = w_bonus ? w_lives_up : lives_q;
            end else if (w_hit) begin
               hit_pulse_d = 1'b1;
               // A simultaneous bonus cancels the loss, so the player always survives it.
               if (w_bonus) begin
                  state_d  = S_INVULN;
                  frames_d = c_INV_FRAMES;
               end else begin
                  lives_d = lives_q - 3'd1;
                  if (lives_q == 3'd1) begin
                     state_d = S_GAMEOVER;
                  end else begin
                     state_d  = S_INVULN;
                     frames_d = c_INV_FRAMES;
                  end
               end
            end else begin
               if (w_bonus) begin
                  lives_d = w_lives_up;
               end
               if ((state_q == S_INVULN) && bus.startOfFrame) begin
                  frames_d = frames_q - 8'd1;
                  if (frames_q == 8'd1) begin
                     state_d = S_PLAY;
                  end
               end
            end
         end
         default: begin
            kills_d = kills_q;
         end
      endcase
   end

   assign bus.lives     = lives_q;
   assign bus.kills     = kills_q;
   assign bus.invuln    = (state_q == S_INVULN);
   assign bus.hit_pulse = hit_pulse_q;
   assign bus.gameOver  = (state_q == S_GAMEOVER);
   assign bus.win       = (state_q == S_WIN);

endmodule

`default_nettype wire
